// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampled UART receiver with valid/ack byte register; UART_RX_PARITY_EN adds an even-parity bit
module uart_rx_oversampled #(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int CLKS_PER_TICK = 27
) (
  input  logic                 fast_clock,
  input  logic                 rst,
  input  logic                 rx_serial,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);
  localparam int CW = CLKS_PER_TICK > 1 ? $clog2(CLKS_PER_TICK) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_nx;
  logic sync1, rxs, prev;
  logic [CW-1:0] ccnt;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] shift;
  logic tick, half, full, last, stop_smp, perr, load;
`ifdef UART_RX_PARITY_EN
  logic pbit;
  assign perr = pbit ^ (^shift);
`else
  assign perr = 1'b0;
`endif
  // next state and per-cycle strobes; tick phase is set by the start edge
  always_comb begin
    tick = ccnt == CW'(CLKS_PER_TICK - 1);
    half = tick && tcnt == TW'(OVERSAMPLE / 2 - 1);
    full = tick && tcnt == TW'(OVERSAMPLE - 1);
    last = bcnt == BW'(DATA_BITS - 1);
    state_nx = state;
    case (state)
      IDLE:    state_nx = prev && !rxs ? START : IDLE;
      START:   state_nx = !half ? START : rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:    state_nx = full && last ? PARITY : DATA;
      PARITY:  state_nx = full ? STOP : PARITY;
`else
      DATA:    state_nx = full && last ? STOP : DATA;
`endif
      STOP:    state_nx = full ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
    stop_smp = state == STOP && full;
    load = stop_smp && rxs && !perr && (!rx_valid || rx_ack);
  end
  // two-flop synchronizer plus edge-history register, idle-high at reset
  always_ff @(posedge fast_clock or negedge rst)
    if (!rst) {sync1, rxs, prev} <= 3'b111;
    else {sync1, rxs, prev} <= {rx_serial, sync1, rxs};
  // state register
  always_ff @(posedge fast_clock or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // prescaler, tick and bit counters, LSB-first shift register
  always_ff @(posedge fast_clock or negedge rst)
    if (!rst) begin
      ccnt <= '0;
      tcnt <= '0;
      bcnt <= '0;
      shift <= '0;
    end else begin
      ccnt <= state == IDLE || tick ? '0 : ccnt + 1'b1;
      tcnt <= state == IDLE || (state == START && half) || full ? '0 : tick ? tcnt + 1'b1 : tcnt;
      bcnt <= state == IDLE ? '0 : state == DATA && full ? bcnt + 1'b1 : bcnt;
      if (state == DATA && full) shift <= {rxs, shift[DATA_BITS-1:1]};
    end
`ifdef UART_RX_PARITY_EN
  // captured parity bit and its one-cycle mismatch pulse at the stop sample
  always_ff @(posedge fast_clock or negedge rst)
    if (!rst) begin
      pbit <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && full) pbit <= rxs;
      parity_err <= stop_smp && perr;
    end
`endif
  // holding register with valid/ack handshake and error pulses
  always_ff @(posedge fast_clock or negedge rst)
    if (!rst) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (load) rx_data <= shift;
      rx_valid <= load || (rx_valid && !rx_ack);
      frame_err <= stop_smp && !rxs;
      overrun_err <= stop_smp && rxs && !perr && rx_valid && !rx_ack;
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed checks of uart_rx_oversampled at 2 clocks/tick, 16 ticks/bit
module tb_uart_rx_oversampled;
  logic fast_clock, rst, rx_serial, rx_ack;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun_err;
  int asserts = 0, fails = 0, fe_cnt = 0, ov_cnt = 0;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  int pe_cnt = 0;
`endif

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .CLKS_PER_TICK(2)) dut (
    .fast_clock(fast_clock),
    .rst(rst),
    .rx_serial(rx_serial),
    .rx_ack(rx_ack),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .overrun_err(overrun_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  initial fast_clock = 1'b0;
  always #5 fast_clock = ~fast_clock;

  // pulse counters
  always @(posedge fast_clock) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun_err) ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge fast_clock);
  endtask

  // start + 8 data bits + stop, 32 cycles each; returns 306 cycles after the start edge
  task automatic frame(input logic [7:0] d, input logic sb);
    rx_serial = 1'b0;
    cyc(32);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      cyc(32);
    end
    rx_serial = sb;
    cyc(18);
  endtask

`ifdef UART_RX_PARITY_EN
  // as frame with a parity bit; returns 338 cycles after the start edge
  task automatic pframe(input logic [7:0] d, input logic pb, input logic sb);
    rx_serial = 1'b0;
    cyc(32);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      cyc(32);
    end
    rx_serial = pb;
    cyc(32);
    rx_serial = sb;
    cyc(18);
  endtask
`endif

  task automatic ack;
    rx_ack = 1'b1;
    cyc(1);
    rx_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rx_serial = 1'b1;
    rx_ack = 1'b0;
    cyc(4);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_oerr", 32'(overrun_err), 0);
    rst = 1'b1;
    cyc(20);
    frame(8'hA5, 1'b1);
    chk("a5_early", 32'(rx_valid), 0);
    cyc(1);
    chk("a5_valid", 32'(rx_valid), 1);
    chk("a5_data", 32'(rx_data), 32'h A5);
    chk("a5_ferr", 32'(frame_err), 0);
    chk("a5_oerr", 32'(overrun_err), 0);
    cyc(33);
    chk("a5_hold", 32'(rx_valid), 1);
    ack();
    chk("a5_ack", 32'(rx_valid), 0);
    rx_serial = 1'b0;
    cyc(8);
    rx_serial = 1'b1;
    cyc(350);
    chk("glitch_valid", 32'(rx_valid), 0);
    chk("glitch_ferr_cnt", 32'(fe_cnt), 0);
    chk("glitch_oerr_cnt", 32'(ov_cnt), 0);
    frame(8'h3C, 1'b0);
    chk("fe_early", 32'(frame_err), 0);
    cyc(1);
    chk("fe_pulse", 32'(frame_err), 1);
    chk("fe_valid", 32'(rx_valid), 0);
    cyc(1);
    chk("fe_width", 32'(frame_err), 0);
    cyc(400);
    chk("low_no_retrig", 32'(fe_cnt), 1);
    chk("low_valid", 32'(rx_valid), 0);
    rx_serial = 1'b1;
    cyc(40);
    frame(8'h55, 1'b1);
    cyc(1);
    chk("x55_valid", 32'(rx_valid), 1);
    chk("x55_data", 32'(rx_data), 32'h55);
    cyc(13);
    ack();
    frame(8'h11, 1'b1);
    cyc(1);
    chk("x11_data", 32'(rx_data), 32'h11);
    cyc(13);
    frame(8'h22, 1'b1);
    cyc(1);
    chk("ovr_pulse", 32'(overrun_err), 1);
    chk("ovr_data", 32'(rx_data), 32'h11);
    chk("ovr_valid", 32'(rx_valid), 1);
    cyc(1);
    chk("ovr_width", 32'(overrun_err), 0);
    cyc(12);
    ack();
    chk("ovr_ack", 32'(rx_valid), 0);
    frame(8'h11, 1'b1);
    cyc(14);
    frame(8'h22, 1'b1);
    rx_ack = 1'b1;
    cyc(1);
    rx_ack = 1'b0;
    chk("ackstop_data", 32'(rx_data), 32'h22);
    chk("ackstop_valid", 32'(rx_valid), 1);
    chk("ackstop_oerr", 32'(overrun_err), 0);
    cyc(13);
    chk("ovr_cnt", 32'(ov_cnt), 1);
    rx_serial = 1'b0;
    cyc(144);
    chk("pre_rst_valid", 32'(rx_valid), 1);
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(rx_valid), 0);
    chk("arst_data", 32'(rx_data), 0);
    rx_serial = 1'b1;
    cyc(5);
    rst = 1'b1;
    cyc(40);
    chk("post_rst_valid", 32'(rx_valid), 0);
    frame(8'h0F, 1'b1);
    cyc(1);
    chk("x0f_valid", 32'(rx_valid), 1);
    chk("x0f_data", 32'(rx_data), 32'h0F);
    cyc(13);
    ack();
`ifdef UART_RX_PARITY_EN
    pframe(8'h07, 1'b0, 1'b1);
    cyc(1);
    chk("par_pulse", 32'(parity_err), 1);
    chk("par_valid", 32'(rx_valid), 0);
    cyc(1);
    chk("par_width", 32'(parity_err), 0);
    cyc(12);
    pframe(8'h07, 1'b1, 1'b1);
    cyc(1);
    chk("par_ok_valid", 32'(rx_valid), 1);
    chk("par_ok_data", 32'(rx_data), 32'h07);
    chk("par_ok_perr", 32'(parity_err), 0);
    cyc(13);
    chk("par_cnt", 32'(pe_cnt), 1);
`endif
    chk("final_ferr_cnt", 32'(fe_cnt), 1);
    chk("final_oerr_cnt", 32'(ov_cnt), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Serial UART receiver and the receive end of the prescaled TX/RX link. It derives its own oversampling tick from `fast_clock`, detects and validates the start bit, and samples data bits LSB-first at bit centre. It checks the stop bit and presents each byte on a valid/ack holding register. It sits between the `rx_serial` pad and the host-side byte consumer, mirroring the transmitter's prescaler and framing.

## Interface
- `DATA_BITS`, default 8: data bits per frame, range 5–8.
- `OVERSAMPLE`, default 16: ticks per bit period; even, ≥ 4.
- `CLKS_PER_TICK`, default 27: `fast_clock` cycles per oversample tick, ≥ 1 (for example 50 MHz / 115200 / 16 ≈ 27).
- `fast_clock`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `rx_serial`, in, 1: asynchronous serial line, idle high.
- `rx_ack`, in, 1: consumer accepts `rx_data`; one-cycle pulse or level.
- `rx_data`, out, `DATA_BITS`: last accepted byte, LSB = first bit received.
- `rx_valid`, out, 1: `rx_data` holds an unconsumed byte.
- `frame_err`, out, 1: one-cycle pulse, stop bit sampled low.
- `overrun_err`, out, 1: one-cycle pulse, byte completed while `rx_valid` was pending.
- `parity_err`, out, 1: one-cycle pulse; present only with `UART_RX_PARITY_EN`.

## Operation
- `rx_serial` passes through a 2-flop synchronizer; a registered copy of the synchronizer output drives falling-edge detection.
- Tick generator: counter 0..`CLKS_PER_TICK`-1, `tick` asserts when count = `CLKS_PER_TICK`-1. The counter is held at 0 in IDLE, so tick phase aligns to the start edge.
- Tick counter: 0..`OVERSAMPLE`-1, advanced on `tick`. Bit counter: 0..`DATA_BITS`-1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: a synchronized falling edge (previous 1, current 0) moves to START and clears the counters. A line held low never retriggers.
- START: after `OVERSAMPLE/2` ticks (bit centre), sample the line.
  - Sample 0: go to DATA.
  - Sample 1: false start; go to IDLE with no outputs.
- DATA: every `OVERSAMPLE` ticks, shift the sample into the shift register MSB-side so the first bit ends at the LSB. After bit `DATA_BITS`-1, go to PARITY or STOP.
- STOP: after `OVERSAMPLE` ticks, sample the line, then go to IDLE.
  - Sample 1 with `rx_valid`=0, or with `rx_valid`=1 and `rx_ack`=1 in the same cycle: load `rx_data`, set `rx_valid`.
  - Sample 1 with `rx_valid`=1 and `rx_ack`=0: discard the byte, pulse `overrun_err`, leave `rx_data` unchanged.
  - Sample 0: pulse `frame_err`, discard the byte, leave `rx_valid` and `rx_data` unchanged.
- `rx_ack` while `rx_valid`=1 clears `rx_valid` on the next edge unless a load occurs in the same cycle. `rx_ack` with `rx_valid`=0 is ignored.
- Reset values: FSM IDLE, all counters 0, `rx_data`=0, `rx_valid`=0, all error outputs 0, synchronizer flops 1.
- Reset asserted mid-frame aborts the frame. After release, a new frame requires a fresh falling edge.

## Timing
- Edge to START: 3 cycles (2 synchronizer flops plus the edge register).
- Bit-centre sample points relative to the detected edge, with T = `OVERSAMPLE`·`CLKS_PER_TICK` cycles:
  - start: T/2;
  - data bit k: T/2 + (k+1)·T;
  - stop: T/2 + (`DATA_BITS`+1)·T (plus one extra T with parity).
- `rx_valid` rises, or the error pulse fires, 1 cycle after the stop sample tick.
- Error pulses are exactly 1 cycle wide.
- The FSM is back in IDLE at the stop centre, so back-to-back frames with a full stop bit are received.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is compiled in and samples one even-parity bit after the data bits.
  - On a parity mismatch at the stop sample, `parity_err` pulses, the byte is discarded and `rx_valid` is unchanged.
  - If the stop bit is also low, `frame_err` pulses as well.
- Not defined: no PARITY state and no `parity_err` port; the frame is start + `DATA_BITS` + stop.

## Test plan
- `CLKS_PER_TICK`=2, `OVERSAMPLE`=16 (bit period 32 cycles), send 0xA5 with a valid stop bit -> `rx_data`=0xA5 and `rx_valid`=1 one cycle after the stop centre; `rx_valid` holds until `rx_ack`, clears one cycle after it; no error pulses.
- Low glitch of 8 cycles on an idle line -> START samples 1 at its centre; no `rx_valid`, no errors, FSM back in IDLE.
- Send 0x3C with the stop bit driven low -> one-cycle `frame_err`; `rx_valid` stays 0; a line held low afterwards does not retrigger, and 0x55 sent after the line returns high is received correctly.
- Send 0x11 then 0x22 back-to-back with no `rx_ack` -> `rx_data`=0x11, one-cycle `overrun_err` at the second stop; asserting `rx_ack` exactly on the second stop cycle instead -> `rx_data`=0x22, `rx_valid` stays 1, no overrun.
- Drive `rst` low during data bit 3 of 0xF0 -> all outputs reset to 0 asynchronously; after release, a full 0x0F frame is received correctly.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 (wrong for even parity) -> `parity_err` pulse, no `rx_valid`; the same frame with parity bit 1 -> `rx_data`=0x07.
